// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the ROM boot loader.
// Holds the loader state encoding and the frame-level defaults.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } boot_state_e;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
    localparam int         LEN_W         = 16;

endpackage

// File: rtl/boot_byte_packer.sv
// Packs an LSB-first byte stream into DATA_W-bit words.
// word/word_valid are combinational so the caller can register them on the accept edge.
module boot_byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              flush,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] byte_ext;
    logic [DATA_W-1:0] merged;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        byte_ext   = DATA_W'(byte_data);
        merged     = (shift_q >> 8) | (byte_ext << (DATA_W - 8));
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_valid = 1'b0;
        if (flush) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = merged;
            if (cnt_q == CNT_W'(BYTES - 1)) begin
                cnt_d      = '0;
                word_valid = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign word = merged;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rom_boot_loader.sv
// Loads a framed, checksummed byte stream into the instruction ROM and
// holds the core in reset until a verified image is stored (or boot is skipped).
module rom_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int         DEPTH          = 128,
    parameter int         DATA_W         = 32,
    parameter logic [7:0] MAGIC          = DEFAULT_MAGIC,
    parameter int         TIMEOUT        = 100000,
    parameter bit         CLEAR_ON_START = 1'b1,
    localparam int        ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              boot_skip,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              core_reset_n,
    output logic              boot_done,
    output logic              boot_error,
    output logic [15:0]       words_loaded
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [LEN_W-1:0]  len_next;
    logic [7:0]        csum_q, csum_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              rx_ready_q, rx_ready_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rom_wdata_q, rom_wdata_d;
    logic              core_reset_n_q, core_reset_n_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_error_q, boot_error_d;

    logic              accept;
    logic              counting;
    logic              timed_out;
    logic              pack_valid;
    logic              pack_flush;
    logic              word_valid;
    logic [DATA_W-1:0] word;

    assign accept     = rx_valid && rx_ready_q;
    assign counting   = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                        (state_q == DATA)   || (state_q == CSUM);
    assign timed_out  = counting && !accept && (idle_q == TO_W'(TIMEOUT - 1));
    assign pack_valid = accept && (state_q == DATA);
    // Any partial word is discarded whenever the loader is outside DATA or gives up on it.
    assign pack_flush = (state_q != DATA) || timed_out;

    boot_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .flush      (pack_flush),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        words_d        = words_q;
        csum_d         = csum_q;
        idle_d         = (counting && !accept) ? idle_q + 1'b1 : '0;
        rom_we_d       = 1'b0;
        rom_addr_d     = rom_addr_q;
        rom_wdata_d    = rom_wdata_q;
        core_reset_n_d = core_reset_n_q;
        boot_done_d    = boot_done_q;
        boot_error_d   = boot_error_q;
        len_next       = {rx_data, len_q[7:0]};

        unique case (state_q)
            IDLE, ERROR: begin
                if (boot_skip) begin
                    state_d        = DONE;
                    core_reset_n_d = 1'b1;
                    boot_done_d    = 1'b1;
                end else if (accept && (rx_data == MAGIC)) begin
                    boot_error_d = 1'b0;
                    words_d      = '0;
                    csum_d       = '0;
                    len_d        = '0;
                    if (CLEAR_ON_START) begin
                        state_d     = CLEAR;
                        rom_we_d    = 1'b1;
                        rom_addr_d  = '0;
                        rom_wdata_d = '0;
                    end else begin
                        state_d = LEN_LO;
                    end
                end
            end
            CLEAR: begin
                // rom_addr_q doubles as the clear pointer; the last write was DEPTH-1.
                if (rom_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = LEN_LO;
                end else begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = rom_addr_q + 1'b1;
                    rom_wdata_d = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d   = LEN_W'(rx_data);
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_next;
                    if (len_next > LEN_W'(DEPTH)) begin
                        state_d      = ERROR;
                        boot_error_d = 1'b1;
                    end else if (len_next == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q + rx_data;
                    if (word_valid) begin
                        rom_we_d    = 1'b1;
                        rom_addr_d  = words_q[ADDR_W-1:0];
                        rom_wdata_d = word;
                        words_d     = words_q + LEN_W'(1);
                        if (words_d == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d        = DONE;
                        core_reset_n_d = 1'b1;
                        boot_done_d    = 1'b1;
                    end else begin
                        state_d      = ERROR;
                        boot_error_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timed_out) begin
            state_d      = ERROR;
            boot_error_d = 1'b1;
        end

        rx_ready_d = (state_d != CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            len_q          <= '0;
            words_q        <= '0;
            csum_q         <= '0;
            idle_q         <= '0;
            rx_ready_q     <= 1'b0;
            rom_we_q       <= 1'b0;
            rom_addr_q     <= '0;
            rom_wdata_q    <= '0;
            core_reset_n_q <= 1'b0;
            boot_done_q    <= 1'b0;
            boot_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            words_q        <= words_d;
            csum_q         <= csum_d;
            idle_q         <= idle_d;
            rx_ready_q     <= rx_ready_d;
            rom_we_q       <= rom_we_d;
            rom_addr_q     <= rom_addr_d;
            rom_wdata_q    <= rom_wdata_d;
            core_reset_n_q <= core_reset_n_d;
            boot_done_q    <= boot_done_d;
            boot_error_q   <= boot_error_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign rom_we       = rom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_wdata    = rom_wdata_q;
    assign core_reset_n = core_reset_n_q;
    assign boot_done    = boot_done_q;
    assign boot_error   = boot_error_q;
    assign words_loaded = words_q;

endmodule
